// File: rtl/gelato_fetch_scheduler_pkg.sv
// Shared constants and fetch-request types for the gelato fetch front end.
// gelato_macros holds the configuration constants; gelato_types builds the datapath types from them.
package gelato_macros;
    localparam int WARP_NUM        = 4;
    localparam int WARP_NUM_WIDTH  = $clog2(WARP_NUM);
    localparam int PC_WIDTH        = 32;
    localparam int SPLIT_NUM_WIDTH = 2;
endpackage

package gelato_types;
    import gelato_macros::*;

    typedef logic [WARP_NUM_WIDTH-1:0]  warp_num_t;
    typedef logic [PC_WIDTH-1:0]        pc_t;
    typedef logic [SPLIT_NUM_WIDTH-1:0] split_table_num_t;

    typedef struct packed {
        warp_num_t        warp;
        pc_t              pc;
        split_table_num_t split_table_num;
    } fetch_req_t;
endpackage

// File: rtl/gelato_fetch_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request after the pointer, wrapping around.
// N must be a power of two so the index addition wraps naturally.
module gelato_rr_arbiter #(
    parameter int N     = gelato_macros::WARP_NUM,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_grant_valid,
    output logic [IDX_W-1:0] o_grant_idx
);
    logic [IDX_W-1:0] w_idx;

    // Scan farthest-first so the nearest request after the pointer is the last to win.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        w_idx         = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = i_ptr + IDX_W'(k);
            if (i_req[w_idx]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = w_idx;
            end
        end
    end
endmodule

// File: rtl/gelato_fetch_scheduler.sv
// Fetch scheduler: round-robin issue of one registered fetch request per cycle from the
// per-warp PC table, with one outstanding fetch per warp until release or flush.
module gelato_fetch_scheduler #(
    parameter int WARP_NUM        = gelato_macros::WARP_NUM,
    parameter int WARP_NUM_WIDTH  = $clog2(WARP_NUM),
    parameter int PC_WIDTH        = gelato_macros::PC_WIDTH,
    parameter int SPLIT_NUM_WIDTH = gelato_macros::SPLIT_NUM_WIDTH
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic                                      i_rdy,
    input  logic [WARP_NUM-1:0]                       i_pct_valid,
    input  logic [WARP_NUM-1:0][PC_WIDTH-1:0]         i_pct_pc,
    input  logic [WARP_NUM-1:0][SPLIT_NUM_WIDTH-1:0]  i_pct_split_table_num,
    input  logic                                      i_release_valid,
    input  logic [WARP_NUM_WIDTH-1:0]                 i_release_warp,
    input  logic                                      i_flush_valid,
    input  logic [WARP_NUM_WIDTH-1:0]                 i_flush_warp,
    output logic                                      o_fetch_valid,
    input  logic                                      i_fetch_ready,
    output logic [WARP_NUM_WIDTH-1:0]                 o_fetch_warp,
    output logic [PC_WIDTH-1:0]                       o_fetch_pc,
    output logic [SPLIT_NUM_WIDTH-1:0]                o_fetch_split_table_num,
    output logic                                      o_busy,
    output logic                                      o_err
);
    logic                       r_fetch_valid;
    logic [WARP_NUM_WIDTH-1:0]  r_fetch_warp;
    logic [PC_WIDTH-1:0]        r_fetch_pc;
    logic [SPLIT_NUM_WIDTH-1:0] r_fetch_split_table_num;
    logic [WARP_NUM-1:0]        r_pending;
    logic [WARP_NUM_WIDTH-1:0]  r_rr_ptr;
    logic                       r_err;

    logic [WARP_NUM-1:0]        w_eligible;
    logic                       w_grant_valid;
    logic [WARP_NUM_WIDTH-1:0]  w_grant_idx;
    logic                       w_can_load;
    logic                       w_load;
    logic                       w_flush_hit;
    logic                       w_release_bad;
    logic [WARP_NUM-1:0]        w_pending_next;

    assign w_eligible    = i_pct_valid & ~r_pending;
    assign w_can_load    = ~r_fetch_valid | i_fetch_ready;
    assign w_load        = w_can_load & w_grant_valid;
    // An accepted request is never revoked; only a stalled one is dropped by flush.
    assign w_flush_hit   = i_flush_valid & r_fetch_valid & ~i_fetch_ready &
                           (r_fetch_warp == i_flush_warp);
    assign w_release_bad = i_release_valid & ~r_pending[i_release_warp];

    gelato_rr_arbiter #(
        .N     (WARP_NUM),
        .IDX_W (WARP_NUM_WIDTH)
    ) u_arbiter (
        .i_req         (w_eligible),
        .i_ptr         (r_rr_ptr),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    always_comb begin
        w_pending_next = r_pending;
        if (i_release_valid) w_pending_next[i_release_warp] = 1'b0;
        if (i_flush_valid)   w_pending_next[i_flush_warp]   = 1'b0;
        if (w_load)          w_pending_next[w_grant_idx]    = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_valid           <= 1'b0;
            r_fetch_warp            <= '0;
            r_fetch_pc              <= '0;
            r_fetch_split_table_num <= '0;
            r_pending               <= '0;
            r_rr_ptr                <= WARP_NUM_WIDTH'(WARP_NUM - 1);
            r_err                   <= 1'b0;
        end else if (i_rdy) begin
            r_pending <= w_pending_next;
            if (w_release_bad) r_err <= 1'b1;
            if (w_load) begin
                r_fetch_valid           <= 1'b1;
                r_fetch_warp            <= w_grant_idx;
                r_fetch_pc              <= i_pct_pc[w_grant_idx];
                r_fetch_split_table_num <= i_pct_split_table_num[w_grant_idx];
                r_rr_ptr                <= w_grant_idx;
            end else if (w_can_load || w_flush_hit) begin
                r_fetch_valid <= 1'b0;
            end
        end
    end

    assign o_fetch_valid           = r_fetch_valid;
    assign o_fetch_warp            = r_fetch_warp;
    assign o_fetch_pc              = r_fetch_pc;
    assign o_fetch_split_table_num = r_fetch_split_table_num;
    assign o_busy                  = (|r_pending) | r_fetch_valid;
    assign o_err                   = r_err;
endmodule

// File: doc/gelato_fetch_scheduler.md
Name: gelato_fetch_scheduler

Overview:
- Consumes the per-warp PC table produced by the split table: valid, pc and split_table_num for every warp.
- Picks one eligible warp per cycle, round-robin, and issues a registered fetch request to the instruction-fetch stage over a valid/ready handshake.
- Tracks one outstanding fetch per warp. A warp stays blocked from fetch issue until decode releases it or it is flushed.

Parameters:
- WARP_NUM, 4, number of warps; power of two, at least 2.
- WARP_NUM_WIDTH, $clog2(WARP_NUM), warp index width.
- PC_WIDTH, 32, program counter width.
- SPLIT_NUM_WIDTH, 2, split_table_num width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; 0 freezes all state.
- pct_valid  in  WARP_NUM  per-warp PC-table entry valid.
- pct_pc  in  WARP_NUM x PC_WIDTH  per-warp next PC.
- pct_split_table_num  in  WARP_NUM x SPLIT_NUM_WIDTH  per-warp active split entry.
- release_valid  in  1  decode has consumed the warp's fetched instruction; unblock it.
- release_warp  in  WARP_NUM_WIDTH  warp to unblock.
- flush_valid  in  1  redirect; discard the warp's in-flight request.
- flush_warp  in  WARP_NUM_WIDTH  warp to flush.
- fetch_valid  out  1  request valid.
- fetch_ready  in  1  fetch stage accepts the request.
- fetch_warp  out  WARP_NUM_WIDTH  warp of the request.
- fetch_pc  out  PC_WIDTH  PC of the request.
- fetch_split_table_num  out  SPLIT_NUM_WIDTH  split entry of the request.
- busy  out  1  any pending bit set, or fetch_valid.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values: fetch_valid=0, fetch_warp=0, fetch_pc=0, fetch_split_table_num=0, pending=0, rr_ptr=WARP_NUM-1, err=0. Reset overrides every other input.
- rdy=0: every register holds. fetch_ready, release and flush are ignored; the sources must hold them until rdy=1.
- Eligibility: eligible[i] = pct_valid[i] & ~pending[i]. Uses registered pending only, so a release takes effect the following cycle.
- Arbitration: search for the first eligible warp starting at rr_ptr+1 (mod WARP_NUM), wrapping around.
- Output register loads when (~fetch_valid | fetch_ready) and an eligible warp exists:
  - fetch_* take the granted warp's pct fields.
  - fetch_valid=1.
  - pending[grant] sets.
  - rr_ptr becomes grant.
- Latency: eligible in cycle N gives fetch_valid in cycle N+1. Back-to-back grants occur when fetch_ready=1.
- Accept with nothing eligible: fetch_valid clears next cycle.
- Stall (fetch_valid & ~fetch_ready): all fetch_* outputs hold stable and no grant occurs.
- Pending clears on release_valid for release_warp, or on flush_valid for flush_warp.
- Release for a non-pending warp: ignored, and err sets.
- Flush:
  - If the output register holds flush_warp and fetch_ready=0: fetch_valid clears next cycle and no new grant happens that cycle.
  - If fetch_ready=1 that same cycle: the request is considered accepted and is not revoked; the fetch stage drops it by flush_warp.
- Release and flush for the same warp in the same cycle: pending clears; err is not set.
- Release or flush for warp X in the same cycle as a grant to warp Y≠X: both take effect.
- A grant to the warp being released is impossible, because that warp's registered pending bit is set.
- pct_valid deasserting after a grant has no effect on the issued request.

Decomposition:
- gelato_types package holds warp_num_t, pc_t and split_table_num_t, plus a fetch_req_t struct {warp, pc, split_table_num}.
- WARP_NUM / WARP_NUM_WIDTH constants come from gelato_macros.
- One sub-module: gelato_rr_arbiter, a parameterised combinational round-robin pick from (req vector, pointer) giving (grant_valid, grant_idx).
- Pending bits, output register, flush handling and err stay in the top module.

Test Plan:
- Reset, then all pct_valid=1 with fetch_ready=1 and release of each warp 2 cycles after issue → fetch_warp sequence 0,1,2,3,0,…, one per cycle while eligible.
- pct_valid=4'b0101, fetch_ready held 0 for 5 cycles → fetch_warp=0, pc stable and fetch_valid=1 throughout; after ready, next grant is warp 2.
- Warp 1 issued and not released, pct_valid=4'b0010 → no further request. Release warp 1 at cycle T → next fetch_valid for warp 1 at T+2.
- Output holds warp 3 with ready=0, flush_valid with flush_warp=3 → fetch_valid=0 next cycle, pending[3]=0, and warp 3 can re-issue at the new pct_pc.
- release_valid for non-pending warp 2 → err=1 and stays set until rst. A same-cycle release+flush of pending warp 0 → err unchanged.
- Hold rdy=0 for 3 cycles with ready=1 and eligible warps → outputs, rr_ptr and pending unchanged; behaviour resumes exactly on rdy=1.
